iob_cache_req_bridge: RTL

//  Upstream stage of the AXI-backed IOb cache: converts a valid/ready request stream from engine logic into
//  IOb-native front-end transactions (avalid/ready/rvalid) and returns read data on a backpressurable response stream.
//  IOb rvalid cannot be stalled, so the bridge reserves response-FIFO space before issuing any read.

---
 rtl/iob_cache_bridge_pkg.sv | 22 ++
 rtl/iob_cache_bridge_fifo.sv | 47 ++++
 rtl/iob_cache_req_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/iob_cache_bridge_pkg.sv
// rtl/iob_cache_bridge_pkg.sv - shared widths and response entry type for the IOb cache request bridge
package iob_cache_bridge_pkg;

    localparam int DEF_ADDR_W  = 30;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ID_W    = 4;
    localparam int DEF_DEPTH_W = 2;

    localparam int DEPTH = 2 ** DEF_DEPTH_W;
    localparam int RES_W = DEF_DEPTH_W + 1;

    typedef struct packed {
        logic                  write;
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_DATA_W-1:0] rdata;
    } rsp_entry_t;

    function automatic int depth_of(input int depth_w);
        return 2 ** depth_w;
    endfunction

endpackage

// File: rtl/iob_cache_bridge_fifo.sv
// rtl/iob_cache_bridge_fifo.sv - first-word-fall-through sync FIFO with full/empty/level
module iob_cache_bridge_fifo #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   pop_data,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_W:0]   level
);

    localparam logic [DEPTH_W:0] DEPTH_L = (DEPTH_W + 1)'(2 ** DEPTH_W);

    logic [WIDTH-1:0] mem [2**DEPTH_W];
    logic [DEPTH_W:0] wr_ptr;
    logic [DEPTH_W:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == DEPTH_L);
    assign empty    = (level == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr[DEPTH_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; empty gates every consumer of pop_data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/iob_cache_req_bridge.sv
// rtl/iob_cache_req_bridge.sv - valid/ready request stream to IOb front-end bridge with in-order read responses
// Optional write acknowledges: IOB_CACHE_REQ_BRIDGE_WACK_EN
module iob_cache_req_bridge
    import iob_cache_bridge_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = DEF_ID_W,
    parameter int DEPTH_W = DEF_DEPTH_W
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_wstrb_i,
    input  logic [ID_W-1:0]     req_id_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic [ID_W-1:0]     rsp_id_o,
    output logic                rsp_write_o,
    output logic                iob_avalid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_ready_i,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    output logic                busy_o,
    output logic                error_o
);

    localparam int CNT_W = DEPTH_W + 1;
    localparam logic [CNT_W-1:0] RSP_DEPTH = CNT_W'(depth_of(DEPTH_W));
`ifdef IOB_CACHE_REQ_BRIDGE_WACK_EN
    localparam int RSP_W = 1 + ID_W + DATA_W;
`else
    localparam int RSP_W = ID_W + DATA_W;
`endif

    logic                run_q;
    logic                hold_valid;
    logic [ID_W-1:0]     hold_id;
    logic [CNT_W-1:0]    reserved;
    logic                req_is_write, hold_is_write, slot_free;
    logic                req_fire, iob_fire, rsp_pop, reserve_inc, rd_push;
    logic                tag_empty, tag_full, rsp_empty, rsp_full, rsp_push;
    logic [DEPTH_W:0]    tag_level, rsp_level;
    logic [ID_W-1:0]     tag_head;
    logic [RSP_W-1:0]    rsp_push_data, rsp_head;
    logic                unused_fifo_status;

    assign req_is_write  = |req_wstrb_i;
    assign hold_is_write = |iob_wstrb_o;
    assign iob_avalid_o  = hold_valid;
    assign iob_fire      = hold_valid & iob_ready_i;
    assign slot_free     = reserved < RSP_DEPTH;
    assign req_fire      = req_valid_i & req_ready_o;
    assign rsp_valid_o   = ~rsp_empty;
    assign rsp_pop       = rsp_valid_o & rsp_ready_i;
    assign rd_push       = iob_rvalid_i & ~tag_empty;
    assign busy_o        = hold_valid | (reserved != '0);
    assign rsp_rdata_o   = rsp_valid_o ? rsp_head[DATA_W-1:0] : '0;
    assign rsp_id_o      = rsp_valid_o ? rsp_head[DATA_W +: ID_W] : '0;
    assign unused_fifo_status = ^{tag_full, tag_level, rsp_full, rsp_level};

`ifdef IOB_CACHE_REQ_BRIDGE_WACK_EN
    logic            pend_valid;
    logic [ID_W-1:0] pend_id;
    logic            ack_now;

    assign ack_now     = iob_fire & hold_is_write;
    // A new write may not enter while its ack could collide with one already parked.
    assign req_ready_o = run_q & (~hold_valid | iob_fire) & slot_free
                       & (~req_is_write | ~(pend_valid | (ack_now & rd_push)));
    assign reserve_inc = req_fire;
    assign rsp_push    = rd_push | ack_now | pend_valid;
    assign rsp_write_o = rsp_valid_o & rsp_head[RSP_W-1];

    always_comb begin
        rsp_push_data = {1'b1, hold_id, {DATA_W{1'b0}}};
        if (rd_push)         rsp_push_data = {1'b0, tag_head, iob_rdata_i};
        else if (pend_valid) rsp_push_data = {1'b1, pend_id, {DATA_W{1'b0}}};
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pend_valid <= 1'b0;
            pend_id    <= '0;
        end else if (ack_now & (rd_push | pend_valid)) begin
            pend_valid <= 1'b1;
            pend_id    <= hold_id;
        end else if (pend_valid & ~rd_push) begin
            pend_valid <= 1'b0;
        end
    end
`else
    assign req_ready_o   = run_q & (~hold_valid | iob_fire) & (req_is_write | slot_free);
    assign reserve_inc   = req_fire & ~req_is_write;
    assign rsp_push      = rd_push;
    assign rsp_push_data = {tag_head, iob_rdata_i};
    assign rsp_write_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            run_q       <= 1'b0;
            hold_valid  <= 1'b0;
            hold_id     <= '0;
            iob_addr_o  <= '0;
            iob_wdata_o <= '0;
            iob_wstrb_o <= '0;
            reserved    <= '0;
            error_o     <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (req_fire) begin
                hold_valid  <= 1'b1;
                hold_id     <= req_id_i;
                iob_addr_o  <= req_addr_i;
                iob_wdata_o <= req_wdata_i;
                iob_wstrb_o <= req_wstrb_i;
            end else if (iob_fire) begin
                hold_valid <= 1'b0;
            end
            case ({reserve_inc, rsp_pop})
                2'b10:   reserved <= reserved + CNT_W'(1);
                2'b01:   reserved <= reserved - CNT_W'(1);
                default: reserved <= reserved;
            endcase
            if (iob_rvalid_i & tag_empty) error_o <= 1'b1;
        end
    end

    iob_cache_bridge_fifo #(.WIDTH(ID_W), .DEPTH_W(DEPTH_W)) u_tag_fifo (
        .clk       (clk_i),
        .rst_n     (arst_n_i),
        .push      (iob_fire & ~hold_is_write),
        .push_data (hold_id),
        .pop       (rd_push),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .level     (tag_level)
    );

    iob_cache_bridge_fifo #(.WIDTH(RSP_W), .DEPTH_W(DEPTH_W)) u_rsp_fifo (
        .clk       (clk_i),
        .rst_n     (arst_n_i),
        .push      (rsp_push),
        .push_data (rsp_push_data),
        .pop       (rsp_pop),
        .pop_data  (rsp_head),
        .full      (rsp_full),
        .empty     (rsp_empty),
        .level     (rsp_level)
    );

endmodule
